// File: rtl/audio_attr_bank.sv
// -----------------------------------------------------------------------------
// audio_attr_bank
//
// Byte-writable, word-readable attribute store with a built-in clear engine.
// Each of NUM_CH entries is ATTR_BYTES bytes wide. Writes land one byte at a
// time, and reads return a whole entry with one cycle of latency. A clear,
// started by reset or by clr_i, zeroes one entry per cycle. While it runs the
// block is busy and accepts no accesses.
//
// Ports
//   clk_i      : single rising-edge clock
//   rst_i      : synchronous active-high reset; starts a full clear
//   clr_i      : pulse requesting a zero of every entry (restarts a clear)
//   wr_en_i    : byte write strobe
//   wr_addr_i  : byte address {entry[CW-1:0], lane[BW-1:0]}
//   wr_data_i  : write byte
//   rd_en_i    : read request
//   rd_addr_i  : entry to read
//   rd_data_o  : read word, lane k at bits [8k+7:8k], holds when no read
//   rd_valid_o : rd_data_o carries the previous cycle's read request
//   busy_o     : clear engine active
//   wr_drop_o  : one-cycle flag for a write discarded while busy
// -----------------------------------------------------------------------------
module audio_attr_bank #(
    parameter  int NUM_CH     = 32,
    parameter  int ATTR_BYTES = 4,
    localparam int CW         = $clog2(NUM_CH),
    localparam int BW         = (ATTR_BYTES > 1) ? $clog2(ATTR_BYTES) : 1,
    localparam int DW         = 8 * ATTR_BYTES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [CW+BW-1:0] wr_addr_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_en_i,
    input  logic [CW-1:0]    rd_addr_i,
    output logic [DW-1:0]    rd_data_o,
    output logic             rd_valid_o,
    output logic             busy_o,
    output logic             wr_drop_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [NUM_CH];

    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          wr_drop_q;

    logic [CW-1:0] wr_entry;
    logic [BW-1:0] wr_lane;
    logic          idle;
    logic          wr_accept;
    logic          rd_accept;

    assign wr_entry  = wr_addr_i[CW+BW-1:BW];
    // With a single byte per entry the lone address bit has no lane to pick.
    assign wr_lane   = wr_addr_i[BW-1:0] & BW'(ATTR_BYTES - 1);
    assign idle      = (state_q == IDLE);
    assign wr_accept = idle && wr_en_i;
    assign rd_accept = idle && rd_en_i;

    // ------------------------------------------------------------------
    // Clear engine: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns state_d/cnt_d; a missed branch would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // NUM_CH is a power of two, so the counter wraps modulo NUM_CH.
                cnt_d = cnt_q + 1'b1;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(NUM_CH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Clear engine: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (wr_en_i) begin
                mem[wr_entry][{wr_lane, 3'b000} +: 8] <= wr_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port and status flags
    // ------------------------------------------------------------------
    // The read samples mem before this edge's write lands, which gives
    // read-before-write on a same-entry collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            wr_drop_q  <= wr_en_i && !idle;
            if (rd_accept) begin
                rd_data_q <= mem[rd_addr_i];
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign wr_drop_o  = wr_drop_q;
    assign busy_o     = (state_q == CLEAR);

    // wr_accept documents the idle-write condition used by the storage block.
    logic unused_ok;
    assign unused_ok = wr_accept;

endmodule

// File: tb/tb_audio_attr_bank.sv
// -----------------------------------------------------------------------------
// tb_audio_attr_bank
//
// Bench for audio_attr_bank. A 32x4 instance runs against a behavioural model
// kept as a byte array plus a count of clear cycles still to run. An 8x8
// instance covers the widest lane layout.
// -----------------------------------------------------------------------------
module tb_audio_attr_bank;

    localparam int A_CH = 32;
    localparam int A_BY = 4;
    localparam int B_CH = 8;
    localparam int B_BY = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (32 entries x 4 bytes)
    logic        rst = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid, busy, wr_drop;

    // Instance B (8 entries x 8 bytes)
    logic        b_rst = 1'b0, b_clr = 1'b0, b_wr_en = 1'b0, b_rd_en = 1'b0;
    logic [5:0]  b_wr_addr = '0;
    logic [7:0]  b_wr_data = '0;
    logic [2:0]  b_rd_addr = '0;
    logic [63:0] b_rd_data;
    logic        b_rd_valid, b_busy, b_wr_drop;

    audio_attr_bank #(.NUM_CH(A_CH), .ATTR_BYTES(A_BY)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .busy_o(busy), .wr_drop_o(wr_drop)
    );

    audio_attr_bank #(.NUM_CH(B_CH), .ATTR_BYTES(B_BY)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .clr_i(b_clr),
        .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid),
        .busy_o(b_busy), .wr_drop_o(b_wr_drop)
    );

    int passed = 0;
    int total  = 0;

    // ------------------------------------------------------------------
    // Reference model for instance A
    // ------------------------------------------------------------------
    logic [7:0]  mdl [A_CH][A_BY];
    int          clear_left = 0;
    logic [31:0] exp_rd_data = '0;
    logic        exp_rd_valid = 1'b0;
    logic        exp_wr_drop = 1'b0;

    function automatic logic [31:0] mdl_word(int e);
        logic [31:0] w;
        for (int k = 0; k < A_BY; k++) w[8*k +: 8] = mdl[e][k];
        return w;
    endfunction

    task automatic mdl_zero();
        for (int e = 0; e < A_CH; e++)
            for (int k = 0; k < A_BY; k++) mdl[e][k] = 8'h00;
    endtask

    // Advance the model by the current inputs, then clock and settle.
    task automatic cycle();
        logic busy_now;
        if (rst) begin
            clear_left   = A_CH;
            exp_rd_valid = 1'b0;
            exp_rd_data  = '0;
            exp_wr_drop  = 1'b0;
            mdl_zero();
        end else begin
            busy_now     = (clear_left > 0);
            exp_wr_drop  = busy_now && wr_en;
            exp_rd_valid = !busy_now && rd_en;
            if (exp_rd_valid) exp_rd_data = mdl_word(int'(rd_addr));
            if (!busy_now && wr_en) mdl[int'(wr_addr) / A_BY][int'(wr_addr) % A_BY] = wr_data;
            if (busy_now) clear_left--;
            // Nothing is accepted during a clear, so zeroing the model up
            // front is observably the same as zeroing entry by entry.
            if (clr) begin
                clear_left = A_CH;
                mdl_zero();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr = 0; wr_en = 0; rd_en = 0;
    endtask

    // Count consecutive busy samples, starting with the current one.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            cycle();
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        int n;
        rst = 1; cycle(); rst = 0;
        total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passed++;
        total++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
        total++; if (wr_drop !== 1'b0) $display("FAIL reset_wr_drop: got %b want 0", wr_drop); else passed++;
        count_busy(n);
        total++; if (n != A_CH) $display("FAIL reset_busy_len: got %0d want %0d", n, A_CH); else passed++;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; rd_addr = 5'($urandom_range(0, A_CH - 1)); cycle();
            total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0)
                $display("FAIL reset_read: got v=%b d=%h want v=1 d=00000000", rd_valid, rd_data);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_byte_write();
        logic [7:0] bytes_in [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 7'(8'h14 + i); wr_data = bytes_in[i]; cycle();
        end
        wr_en = 0; rd_en = 1; rd_addr = 5'd5; cycle(); rd_en = 0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 32'h44332211)
            $display("FAIL byte_write: got v=%b d=%h want v=1 d=44332211", rd_valid, rd_data);
        else passed++;
    endtask

    task automatic test_read_before_write();
        wr_en = 1; wr_addr = 7'h16; wr_data = 8'hAA; rd_en = 1; rd_addr = 5'd5; cycle();
        wr_en = 0;
        total++; if (rd_data !== 32'h44332211) $display("FAIL rbw_same_cycle: got %h want 44332211", rd_data); else passed++;
        cycle();
        total++; if (rd_data !== 32'h44AA2211) $display("FAIL rbw_next_read: got %h want 44aa2211", rd_data); else passed++;
        rd_en = 0; cycle();
        total++; if (rd_valid !== 1'b0 || rd_data !== 32'h44AA2211)
            $display("FAIL read_hold: got v=%b d=%h want v=0 d=44aa2211", rd_valid, rd_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 7'($urandom_range(0, 127)); wr_data = 8'($urandom); cycle();
        end
        wr_en = 0;
        for (int e = 0; e < A_CH; e++) begin
            rd_en = 1; rd_addr = 5'(e); cycle();
            total++; if (rd_valid !== 1'b1 || rd_data !== exp_rd_data)
                $display("FAIL back_to_back[%0d]: got v=%b d=%h want v=1 d=%h", e, rd_valid, rd_data, exp_rd_data);
            else passed++;
        end
        rd_en = 0;
    endtask

    task automatic test_clear_drop();
        int n;
        wr_en = 1; wr_addr = 7'h00; wr_data = 8'h99; cycle(); wr_en = 0;
        clr = 1; cycle(); clr = 0;
        cycle(); cycle();
        rd_en = 1; rd_addr = 5'd0;
        wr_en = 1; wr_addr = 7'h00; wr_data = 8'h55; cycle();
        wr_en = 0; rd_en = 0;
        total++; if (wr_drop !== 1'b1) $display("FAIL drop_pulse: got %b want 1", wr_drop); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL read_in_clear: got %b want 0", rd_valid); else passed++;
        cycle();
        total++; if (wr_drop !== 1'b0) $display("FAIL drop_one_cycle: got %b want 0", wr_drop); else passed++;
        count_busy(n);
        total++; if (n != A_CH - 4) $display("FAIL clear_len: got %0d want %0d", n, A_CH - 4); else passed++;
        rd_en = 1; rd_addr = 5'd0; cycle(); rd_en = 0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0)
            $display("FAIL clear_entry0: got v=%b d=%h want v=1 d=00000000", rd_valid, rd_data);
        else passed++;
    endtask

    task automatic test_restart();
        int n;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1; wr_addr = 7'($urandom_range(0, 127)); wr_data = 8'($urandom_range(1, 255)); cycle();
        end
        wr_en = 0;
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < 20; i++) cycle();
        rst = 1; cycle(); rst = 0;
        count_busy(n);
        total++; if (n != A_CH) $display("FAIL rst_mid_clear_len: got %0d want %0d", n, A_CH); else passed++;
        for (int e = 0; e < A_CH; e++) begin
            rd_en = 1; rd_addr = 5'(e); cycle();
            total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0)
                $display("FAIL rst_mid_clear_read[%0d]: got v=%b d=%h want v=1 d=00000000", e, rd_valid, rd_data);
            else passed++;
        end
        rd_en = 0;
        clr = 1; cycle(); clr = 0;
        for (int i = 0; i < 10; i++) cycle();
        clr = 1; cycle(); clr = 0;
        count_busy(n);
        total++; if (n != A_CH) $display("FAIL clr_mid_clear_len: got %0d want %0d", n, A_CH); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr     = ($urandom_range(0, 79) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = 7'($urandom);
            wr_data = 8'($urandom);
            rd_en   = $urandom_range(0, 1);
            rd_addr = 5'($urandom);
            cycle();
            total++; if (rd_valid !== exp_rd_valid || rd_data !== exp_rd_data ||
                         wr_drop !== exp_wr_drop || busy !== (clear_left > 0))
                $display("FAIL random[%0d]: got v=%b d=%h drop=%b busy=%b want v=%b d=%h drop=%b busy=%b",
                         i, rd_valid, rd_data, wr_drop, busy,
                         exp_rd_valid, exp_rd_data, exp_wr_drop, clear_left > 0);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_wide();
        int n;
        b_rst = 1; cycle(); b_rst = 0;
        n = 0;
        while (b_busy === 1'b1 && n < 100) begin
            n++;
            cycle();
        end
        total++; if (n != B_CH) $display("FAIL wide_busy_len: got %0d want %0d", n, B_CH); else passed++;
        b_wr_en = 1; b_wr_addr = 6'h3F; b_wr_data = 8'hFF; cycle(); b_wr_en = 0;
        b_rd_en = 1; b_rd_addr = 3'd7; cycle();
        total++; if (b_rd_valid !== 1'b1 || b_rd_data !== 64'hFF00_0000_0000_0000)
            $display("FAIL wide_lane7: got v=%b d=%h want v=1 d=ff00000000000000", b_rd_valid, b_rd_data);
        else passed++;
        b_rd_addr = 3'd6; cycle(); b_rd_en = 0;
        total++; if (b_rd_data !== 64'h0) $display("FAIL wide_neighbour: got %h want 0", b_rd_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_read_before_write();
        test_back_to_back();
        test_clear_drop();
        test_restart();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/audio_attr_bank.md
AUDIO_ATTR_BANK -- requirements
Module: audio_attr_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 32, meaning the number of attribute entries (power of two, 2..256).
REQ-002 The block SHALL have parameter ATTR_BYTES, default 4, meaning bytes per entry (power of two, 1..8).
REQ-003 The block SHALL define the derived widths CW=clog2(NUM_CH), BW=clog2(ATTR_BYTES) (minimum 1), and DW=8*ATTR_BYTES.
REQ-004 The block SHALL have the port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have the port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have the port clr_i, input, 1 bit: a pulse that requests zeroing of all entries.
REQ-007 The block SHALL have the port wr_en_i, input, 1 bit: byte write strobe.
REQ-008 The block SHALL have the port wr_addr_i, input, CW+BW bits: byte address; the upper CW bits select the entry and the lower BW bits select the byte lane.
REQ-009 The block SHALL have the port wr_data_i, input, 8 bits: the write byte.
REQ-010 The block SHALL have the port rd_en_i, input, 1 bit: read request.
REQ-011 The block SHALL have the port rd_addr_i, input, CW bits: read entry index.
REQ-012 The block SHALL have the port rd_data_o, output, DW bits: read word, with byte lane k at bits [8k+7:8k].
REQ-013 The block SHALL have the port rd_valid_o, output, 1 bit: rd_data_o is valid for the request issued in the previous cycle.
REQ-014 The block SHALL have the port busy_o, output, 1 bit: the clear engine is active; writes and reads are not accepted.
REQ-015 The block SHALL have the port wr_drop_o, output, 1 bit: a one-cycle pulse that flags a write discarded while busy.

Function
REQ-016 The block SHALL implement a clear engine with two states: IDLE and CLEAR.
REQ-017 The block SHALL enter CLEAR from IDLE on clr_i=1, with clear counter=0; clr_i while already in CLEAR SHALL restart the counter at 0.
REQ-018 In CLEAR, the block SHALL write entry[counter]=0 (all lanes) each cycle and increment the counter; after writing entry NUM_CH-1 it SHALL return to IDLE, so CLEAR lasts exactly NUM_CH cycles.
REQ-019 The block SHALL assert busy_o=1 exactly when the state is CLEAR (registered).
REQ-020 In IDLE with wr_en_i=1, the block SHALL write wr_data_i to byte lane wr_addr_i[BW-1:0] of entry wr_addr_i[CW+BW-1:BW] at the clock edge; other lanes SHALL be unchanged.
REQ-021 With wr_en_i=1 in CLEAR, the block SHALL not modify memory and SHALL pulse wr_drop_o=1 in the next cycle; otherwise wr_drop_o SHALL be 0.
REQ-022 In IDLE with rd_en_i=1, the block SHALL register rd_data_o=entry[rd_addr_i] and rd_valid_o=1 one cycle later (latency 1).
REQ-023 In CLEAR or with rd_en_i=0, the block SHALL drive rd_valid_o=0 next cycle and SHALL hold rd_data_o at its last value.
REQ-024 On a same-cycle read and write to the same entry, rd_data_o SHALL return the pre-write contents (read-before-write).
REQ-025 Back-to-back reads SHALL be accepted every cycle, with no bubbles.
REQ-026 Entry and counter indexing SHALL be modulo NUM_CH, with no out-of-range access.

Reset
REQ-027 With rst_i=1 at a clock edge, the block SHALL set the state to CLEAR, counter=0, rd_valid_o=0, rd_data_o=0, wr_drop_o=0, and busy_o=1 from the next cycle.
REQ-028 After rst_i deasserts, the block SHALL complete a full NUM_CH-cycle clear before accepting any access; rst_i asserted mid-clear SHALL restart the clear from entry 0.
REQ-029 Memory contents SHALL not depend on an initial block; the clear engine is the sole initialiser.

Verification
REQ-030 The bench SHALL cover this scenario: rst_i for 1 cycle → busy_o=1 for exactly 32 cycles, then 0; a read of any entry returns 0x00000000 with rd_valid_o=1 one cycle later.
REQ-031 The bench SHALL cover this scenario: writes of 0x11,0x22,0x33,0x44 to byte addresses 0x14..0x17, then a read of entry 5 → rd_data_o=0x44332211.
REQ-032 The bench SHALL cover this scenario: with entry 5=0x44332211, a write of 0xAA to address 0x16 together with a read of entry 5 in the same cycle → 0x44332211; the next read → 0x44AA2211.
REQ-033 The bench SHALL cover this scenario: clr_i pulse, then a write of 0x55 to address 0x00 on cycle 3 of the clear → wr_drop_o=1 for one cycle; after the clear, entry 0 reads 0.
REQ-034 The bench SHALL cover this scenario: rst_i reasserted at clear cycle 20 → busy_o stays high for 32 more cycles, and all entries read 0.
REQ-035 The bench SHALL cover this scenario: with NUM_CH=8, ATTR_BYTES=8, a write of 0xFF to address 0x3F → entry 7 reads 0xFF00000000000000.
